// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory stage
package mem_pkg;

  // Bus access FSM
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  // Funct3 load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Funct3 store encodings
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Width of the WAIT_R timeout counter
  localparam int TO_W = 8;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store lane replication and load extraction/extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic        is_byte;
  logic        is_half;
  logic        is_unsigned;
  logic [31:0] shifted;

  // Decode access size, build lane mask/data and extend the addressed load lane
  always_comb begin
    is_byte     = (funct3 == F3_LB) || (funct3 == F3_LBU);
    is_half     = (funct3 == F3_LH) || (funct3 == F3_LHU);
    is_unsigned = (funct3 == F3_LBU) || (funct3 == F3_LHU);
    shifted     = load_data >> {offset, 3'b000};
    be          = 4'hF;
    lane_data   = store_data;
    load_ext    = load_data;
    misaligned  = 1'b0;
    if (is_byte) begin
      be        = 4'b0001 << offset;
      lane_data = {4{store_data[7:0]}};
      load_ext  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      be         = offset[1] ? 4'b1100 : 4'b0011;
      lane_data  = {2{store_data[15:0]}};
      load_ext   = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      misaligned = offset[0];
    end else begin
      misaligned = (offset != 2'b00);
    end
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage bus FSM and MEM/WB register; subword access under SUBWORD_ACCESS_EN
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  output logic        DReqO,
  output logic        DWeO,
  output logic [31:0] DAddrO,
  output logic [31:0] DWDataO,
  output logic [3:0]  DBeO,
  input  logic        DGntI,
  input  logic        DRValidI,
  input  logic [31:0] DRDataI,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic        BusErrW
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          state;
  logic [TO_W-1:0] cnt;

  logic        mem_op;
  logic        is_store;
  logic        in_req;
  logic        misaligned;
  logic        timeout;
  logic        done;
  logic        stall;
  logic        load_done;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_ext;

  // A store wins when both load and store flags are set
  assign mem_op   = ResultSrcM | MemWriteM;
  assign is_store = MemWriteM;
  assign in_req   = (state == IDLE) || (state == REQ);

`ifdef SUBWORD_ACCESS_EN
  logic mis_raw;

  mem_lane_align u_align (
    .funct3     (Funct3M),
    .offset     (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .load_data  (DRDataI),
    .be         (be),
    .lane_data  (wdata),
    .load_ext   (rdata_ext),
    .misaligned (mis_raw)
  );

  assign misaligned = mem_op & mis_raw;
  assign addr       = ALUResultM;
`else
  logic unused_funct3;

  assign unused_funct3 = ^Funct3M;
  assign be            = 4'hF;
  assign wdata         = WriteDataM;
  assign rdata_ext     = DRDataI;
  assign misaligned    = 1'b0;
  assign addr          = {ALUResultM[31:2], 2'b00};
`endif

  // A response in the timeout cycle takes priority over the timeout
  assign timeout   = (state == WAIT_R) && (TIMEOUT != 0) && (cnt == TO_LIM);
  assign load_done = (state == WAIT_R) && (DRValidI || timeout);
  assign done      = (is_store & DGntI & in_req) | ((state == WAIT_R) & DRValidI) | timeout | misaligned;
  assign stall     = mem_op & ~done;
  assign StallM    = stall;

  // Bus signals are held at zero during reset so a mid-access reset drops the request
  assign DReqO   = rst_n & mem_op & in_req & ~misaligned;
  assign DWeO    = rst_n & is_store;
  assign DAddrO  = rst_n ? addr  : '0;
  assign DWDataO = rst_n ? wdata : '0;
  assign DBeO    = rst_n ? be    : '0;

  // Bus FSM, WAIT_R timeout counter and MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      BusErrW    <= 1'b0;
    end else begin
      cnt <= ((state == WAIT_R) && !load_done) ? cnt + 1'b1 : '0;
      case (state)
        IDLE, REQ: begin
          if (mem_op && !misaligned) begin
            state <= DGntI ? (is_store ? IDLE : WAIT_R) : REQ;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_R: begin
          if (load_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (stall) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= 1'b0;
        BusErrW    <= 1'b0;
      end else begin
        RegWriteW  <= RegWriteM & ~misaligned;
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        RdW        <= RdM;
        BusErrW    <= misaligned | (timeout & ~DRValidI);
        if (load_done) ReadDataW <= DRValidI ? rdata_ext : '0;
      end
    end
  end

endmodule
